// File: rtl/uart_host_rx.sv
// Host-side UART receiver: oversamples the chip TX line, deframes 8N1 characters
// (optionally with a parity bit), and delivers bytes through a small
// first-word-fall-through FIFO with a valid/ready interface. Framing, parity and
// overflow problems are reported as single-cycle pulses.
module uart_host_rx #(
  parameter int Freq      = 500000,
  parameter int Baud      = 7200,
  parameter int ParityEn  = 0,
  parameter int ParityOdd = 0,
  parameter int FifoDepth = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       frame_err_o,
  output logic       parity_err_o,
  output logic       overflow_o,
  output logic       busy_o
);

  localparam int CyclesPerBit = Freq / Baud;
  localparam int CntW         = $clog2(CyclesPerBit);
  localparam int PtrW         = $clog2(FifoDepth);

  localparam logic [CntW-1:0] HalfLoad = CntW'(CyclesPerBit / 2 - 1);
  localparam logic [CntW-1:0] FullLoad = CntW'(CyclesPerBit - 1);
  localparam logic            OddBit   = (ParityOdd != 0);
  localparam logic            HasPar   = (ParityEn != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        sync_q, sync_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              par_bad_q, par_bad_d;
  logic              frame_err_q, frame_err_d;
  logic              parity_err_q, parity_err_d;
  logic              overflow_q, overflow_d;
  logic [PtrW:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]     rd_ptr_q, rd_ptr_d;
  logic [7:0]        mem_q [FifoDepth];

  logic rx_s;
  logic rx_fall;
  logic push;
  logic do_push;
  logic pop;
  logic fifo_empty;
  logic fifo_full;

  // sync_q[1] is the synchronized line, sync_q[2] its previous value for edge detect
  assign rx_s    = sync_q[1];
  assign rx_fall = sync_q[2] & ~sync_q[1];

  // Deframing FSM: next state, bit counter, shift register and error pulses
  always_comb begin
    state_d      = state_q;
    sync_d       = {sync_q[1:0], rx_i};
    cnt_d        = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    par_bad_d    = par_bad_q;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    push         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_fall) begin
          state_d = START;
          cnt_d   = HalfLoad;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          if (!rx_s) begin
            state_d   = DATA;
            bit_idx_d = 3'd0;
            par_bad_d = 1'b0;
            cnt_d     = FullLoad;
          end else begin
            // Line went back high before mid start bit: treat as a glitch
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = FullLoad;
          if (bit_idx_q == 3'd7) begin
            state_d = HasPar ? PARITY : STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (cnt_q == '0) begin
          par_bad_d = (rx_s != ((^shift_q) ^ OddBit));
          state_d   = STOP;
          cnt_d     = FullLoad;
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
            if (par_bad_q) parity_err_d = 1'b1;
            else           push         = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end
      end
      BREAK: begin
        // Stay here for the whole break so it reports only one framing error
        if (rx_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FIFO control: full/empty from pointers with an extra wrap bit
  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                 (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    pop        = rx_ready_i & ~fifo_empty;
    do_push    = push & (~fifo_full | pop);
    overflow_d = push & fifo_full & ~pop;
    wr_ptr_d   = wr_ptr_q + (PtrW+1)'(do_push);
    rd_ptr_d   = rd_ptr_q + (PtrW+1)'(pop);
  end

  // Control and status registers; synchronizer resets to idle-high
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      sync_q       <= 3'b111;
      cnt_q        <= '0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'h00;
      par_bad_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overflow_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      par_bad_q    <= par_bad_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overflow_q   <= overflow_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // FIFO storage; contents need no reset because the pointers gate visibility
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[PtrW-1:0]] <= shift_q;
  end

  assign rx_valid_o   = ~fifo_empty;
  assign rx_data_o    = fifo_empty ? 8'h00 : mem_q[rd_ptr_q[PtrW-1:0]];
  assign frame_err_o  = frame_err_q;
  assign parity_err_o = parity_err_q;
  assign overflow_o   = overflow_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_host_rx.sv
// Directed bench for uart_host_rx: one 8N1 instance and one odd-parity instance.
module tb_uart_host_rx;

  localparam int CPB = 69;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rdy = 1'b1;
  logic [7:0] data;
  logic       valid, ferr, perr, ovf, busy;

  logic       rx_p = 1'b1;
  logic       rdy_p = 1'b1;
  logic [7:0] data_p;
  logic       valid_p, ferr_p, perr_p, ovf_p, busy_p;

  int checks = 0;
  int errors = 0;

  logic [7:0] pops[$];
  logic [7:0] pops_p[$];
  int nf = 0, np = 0, no = 0;
  int nf_p = 0, np_p = 0, no_p = 0;

  always #5 clk = ~clk;

  uart_host_rx #(.ParityEn(0), .ParityOdd(0), .FifoDepth(4)) dut (
    .clk_i(clk), .rst_i(rst), .rx_i(rx), .rx_data_o(data), .rx_valid_o(valid),
    .rx_ready_i(rdy), .frame_err_o(ferr), .parity_err_o(perr), .overflow_o(ovf),
    .busy_o(busy)
  );

  uart_host_rx #(.ParityEn(1), .ParityOdd(1), .FifoDepth(4)) dut_p (
    .clk_i(clk), .rst_i(rst), .rx_i(rx_p), .rx_data_o(data_p), .rx_valid_o(valid_p),
    .rx_ready_i(rdy_p), .frame_err_o(ferr_p), .parity_err_o(perr_p), .overflow_o(ovf_p),
    .busy_o(busy_p)
  );

  // Record handshakes and pulses on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      if (valid && rdy) pops.push_back(data);
      if (ferr) nf++;
      if (perr) np++;
      if (ovf)  no++;
      if (valid_p && rdy_p) pops_p.push_back(data_p);
      if (ferr_p) nf_p++;
      if (perr_p) np_p++;
      if (ovf_p)  no_p++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic line(input logic v, input bit sel, input int n);
    if (sel) rx_p = v;
    else     rx   = v;
    tick(n);
  endtask

  // par < 0 means no parity bit
  task automatic send_frame(input logic [7:0] d, input int par, input logic stop_bit,
                            input bit sel);
    line(1'b0, sel, CPB);
    for (int i = 0; i < 8; i++) line(d[i], sel, CPB);
    if (par >= 0) line(par[0], sel, CPB);
    line(stop_bit, sel, CPB);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(5);
    checks++;
    if ({valid, ferr, perr, ovf, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 00000", {valid, ferr, perr, ovf, busy});
    end
    checks++;
    if (data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: got %h want 00", data);
    end
    rst = 1'b0;
    tick(20);
  endtask

  task automatic test_basic;
    int p0, f0, e0, o0;
    p0 = pops.size(); f0 = nf; e0 = np; o0 = no;
    rdy = 1'b1;
    send_frame(8'hA5, -1, 1'b1, 1'b0);
    tick(30);
    checks++;
    if (pops.size() - p0 !== 1) begin
      errors++;
      $display("FAIL basic_count: got %0d beats want 1", pops.size() - p0);
    end else begin
      checks++;
      if (pops[p0] !== 8'hA5) begin
        errors++;
        $display("FAIL basic_data: got %h want a5", pops[p0]);
      end
    end
    checks++;
    if ((nf - f0) + (np - e0) + (no - o0) !== 0) begin
      errors++;
      $display("FAIL basic_errs: got %0d pulses want 0", (nf - f0) + (np - e0) + (no - o0));
    end
  endtask

  task automatic test_glitch;
    int p0, f0;
    p0 = pops.size(); f0 = nf;
    line(1'b0, 1'b0, 10);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL glitch_busy_hi: got %b want 1", busy);
    end
    line(1'b0, 1'b0, 10);
    line(1'b1, 1'b0, 100);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_busy_lo: got %b want 0", busy);
    end
    checks++;
    if (pops.size() != p0 || nf != f0) begin
      errors++;
      $display("FAIL glitch_quiet: got %0d beats %0d ferr want 0 0", pops.size() - p0, nf - f0);
    end
  endtask

  task automatic test_break;
    int p0, f0;
    p0 = pops.size(); f0 = nf;
    send_frame(8'h3C, -1, 1'b0, 1'b0);
    line(1'b0, 1'b0, 300);
    line(1'b1, 1'b0, 50);
    checks++;
    if (nf - f0 !== 1) begin
      errors++;
      $display("FAIL break_ferr: got %0d pulses want 1", nf - f0);
    end
    checks++;
    if (pops.size() != p0) begin
      errors++;
      $display("FAIL break_nodata: got %0d beats want 0", pops.size() - p0);
    end
    send_frame(8'h42, -1, 1'b1, 1'b0);
    tick(30);
    checks++;
    if (pops.size() != p0 + 1 || pops[pops.size()-1] !== 8'h42) begin
      errors++;
      $display("FAIL break_recover: got %0d beats last %h want 1 beat 42",
               pops.size() - p0, (pops.size() > 0) ? pops[pops.size()-1] : 8'h00);
    end
  endtask

  task automatic test_overflow;
    int p0, o0;
    logic [7:0] exp;
    p0 = pops.size(); o0 = no;
    rdy = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), -1, 1'b1, 1'b0);
      tick(20);
    end
    checks++;
    if (no - o0 !== 1) begin
      errors++;
      $display("FAIL ovf_pulse: got %0d pulses want 1", no - o0);
    end
    checks++;
    if (valid !== 1'b1 || data !== 8'h01) begin
      errors++;
      $display("FAIL ovf_head: got valid %b data %h want 1 01", valid, data);
    end
    rdy = 1'b1;
    tick(10);
    checks++;
    if (pops.size() - p0 !== 4) begin
      errors++;
      $display("FAIL ovf_drain_count: got %0d want 4", pops.size() - p0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        exp = 8'(i + 1);
        checks++;
        if (pops[p0+i] !== exp) begin
          errors++;
          $display("FAIL ovf_drain_%0d: got %h want %h", i, pops[p0+i], exp);
        end
      end
    end
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL ovf_empty: got valid %b want 0", valid);
    end
  endtask

  task automatic test_parity;
    int p0, e0;
    p0 = pops_p.size(); e0 = np_p;
    // 0x07 has three ones, so odd parity needs a 0 parity bit
    send_frame(8'h07, 0, 1'b1, 1'b1);
    tick(20);
    checks++;
    if (pops_p.size() != p0 + 1 || pops_p[pops_p.size()-1] !== 8'h07 || np_p != e0) begin
      errors++;
      $display("FAIL par_good07: got %0d beats %0d perr want 1 beat 07 0 perr",
               pops_p.size() - p0, np_p - e0);
    end
    send_frame(8'h07, 1, 1'b1, 1'b1);
    tick(20);
    checks++;
    if (np_p - e0 !== 1 || pops_p.size() != p0 + 1) begin
      errors++;
      $display("FAIL par_bad07: got %0d perr %0d beats want 1 1", np_p - e0, pops_p.size() - p0);
    end
    // 0x03 has two ones, so odd parity needs a 1 parity bit
    send_frame(8'h03, 1, 1'b1, 1'b1);
    tick(20);
    checks++;
    if (pops_p.size() != p0 + 2 || pops_p[pops_p.size()-1] !== 8'h03 || np_p - e0 != 1) begin
      errors++;
      $display("FAIL par_good03: got %0d beats %0d perr want 2 1", pops_p.size() - p0, np_p - e0);
    end
    checks++;
    if (nf_p + no_p !== 0) begin
      errors++;
      $display("FAIL par_other: got %0d other pulses want 0", nf_p + no_p);
    end
  endtask

  task automatic test_midframe_reset;
    int p0, f0;
    logic [7:0] d;
    d = 8'h81;
    rdy = 1'b0;
    send_frame(8'h55, -1, 1'b1, 1'b0);
    tick(10);
    checks++;
    if (valid !== 1'b1 || data !== 8'h55) begin
      errors++;
      $display("FAIL mrst_pre: got valid %b data %h want 1 55", valid, data);
    end
    line(1'b0, 1'b0, CPB);
    for (int i = 0; i < 4; i++) line(d[i], 1'b0, CPB);
    rst = 1'b1;
    #1;
    checks++;
    if ({valid, busy, ferr, perr, ovf} !== 5'b0 || data !== 8'h00) begin
      errors++;
      $display("FAIL mrst_now: got %b data %h want 00000 00", {valid, busy, ferr, perr, ovf}, data);
    end
    rx = 1'b1;
    rdy = 1'b1;
    tick(5);
    rst = 1'b0;
    tick(50);
    p0 = pops.size(); f0 = nf;
    send_frame(8'h81, -1, 1'b1, 1'b0);
    tick(30);
    checks++;
    if (pops.size() != p0 + 1 || pops[pops.size()-1] !== 8'h81 || nf != f0) begin
      errors++;
      $display("FAIL mrst_after: got %0d beats %0d ferr want 1 beat 81 0 ferr",
               pops.size() - p0, nf - f0);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_glitch;
    test_break;
    test_overflow;
    test_parity;
    test_midframe_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
